// File: rtl/data_bus_responder_if.sv
// Processor data-port bundle between a core and data_bus_responder.
// The core drives the address/strobe/store side; the responder returns load data.
interface data_bus_responder_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/data_bus_responder.sv
// Memory-mapped data-port responder: 64x32 RAM, LED register, cycle counter, optional
// down-counting timer with sticky expiry flag (compiled in when DATA_BUS_TIMER_EN is defined).
module data_bus_responder (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus,
  output logic [7:0]           Leds,
  output logic                 TimerIrq
);

  localparam int unsigned DW        = 32;
  localparam int unsigned RAM_DEPTH = 64;
  localparam int unsigned RAM_IW    = 6;
  localparam int unsigned LED_W     = 8;

  localparam logic [29:0] WADR_LED   = 30'h040;
  localparam logic [29:0] WADR_CYCLE = 30'h041;
  localparam logic [29:0] WADR_TLOAD = 30'h042;
  localparam logic [29:0] WADR_TSTAT = 30'h043;

  // Address decode works on word addresses; byte offset bits are don't-care.
  logic [29:0]       word_adr;
  logic [RAM_IW-1:0] ram_idx;
  logic              is_ram;
  logic              is_led;
  logic              is_cycle;
  logic              unused_adr_bits;

  assign word_adr        = bus.DataAdr[31:2];
  assign ram_idx         = bus.DataAdr[7:2];
  assign is_ram          = (bus.DataAdr[31:8] == 24'h0);
  assign is_led          = (word_adr == WADR_LED);
  assign is_cycle        = (word_adr == WADR_CYCLE);
  assign unused_adr_bits = ^bus.DataAdr[1:0];

  // RAM holds no reset so it maps onto a plain memory macro.
  logic [DW-1:0] ram_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (bus.MemWrite && is_ram) ram_q[ram_idx] <= bus.WriteData;
  end

  logic [LED_W-1:0] leds_q, leds_d;
  logic [DW-1:0]    cycle_q, cycle_d;

  always_comb begin
    leds_d  = leds_q;
    cycle_d = DW'(cycle_q + DW'(1));
    if (bus.MemWrite && is_led)   leds_d  = bus.WriteData[LED_W-1:0];
    if (bus.MemWrite && is_cycle) cycle_d = bus.WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      leds_q  <= '0;
      cycle_q <= '0;
    end else begin
      leds_q  <= leds_d;
      cycle_q <= cycle_d;
    end
  end

  assign Leds = leds_q;

`ifdef DATA_BUS_TIMER_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] count_q, count_d;
  logic          expired_q, expired_d;
  logic          tload_wr, tstat_clr, expire;

  assign tload_wr  = bus.MemWrite && (word_adr == WADR_TLOAD);
  assign tstat_clr = bus.MemWrite && (word_adr == WADR_TSTAT) && bus.WriteData[0];
  // A TLOAD write pre-empts the 1->0 step, so it also suppresses expiry.
  assign expire    = !tload_wr && (state_q == ST_RUN) && (count_q == DW'(1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = expired_q;
    if (tload_wr) begin
      count_d = bus.WriteData;
      state_d = (bus.WriteData != '0) ? ST_RUN : ST_IDLE;
    end else if (state_q == ST_RUN) begin
      count_d = DW'(count_q - DW'(1));
      if (count_q == DW'(1)) state_d = ST_IDLE;
    end
    // Set beats clear when both land on the same edge.
    if (expire)         expired_d = 1'b1;
    else if (tstat_clr) expired_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign TimerIrq = expired_q;
`else
  assign TimerIrq = 1'b0;
`endif

  always_comb begin
    bus.ReadData = '0;
    if (is_ram)        bus.ReadData = ram_q[ram_idx];
    else if (is_led)   bus.ReadData = {24'h0, leds_q};
    else if (is_cycle) bus.ReadData = cycle_q;
`ifdef DATA_BUS_TIMER_EN
    else if (word_adr == WADR_TLOAD) bus.ReadData = count_q;
    else if (word_adr == WADR_TSTAT) bus.ReadData = {31'h0, expired_q};
`endif
  end

endmodule

// File: doc/data_bus_responder.md
DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: reset that is asynchronous and active-low.
REQ-003 The block SHALL have the port `MemWrite`, input, 1 bit: write strobe from the processor data port.
REQ-004 The block SHALL have the port `DataAdr`, input, 32 bits: byte address from the processor (its ALUResult); bits [1:0] ignored.
REQ-005 The block SHALL have the port `WriteData`, input, 32 bits: store data from the processor.
REQ-006 The block SHALL have the port `ReadData`, output, 32 bits: load data returned to the processor, combinational from DataAdr and current state.
REQ-007 The block SHALL have the port `Leds`, output, 8 bits: LED register contents.
REQ-008 The block SHALL have the port `TimerIrq`, output, 1 bit: sticky timer-expired flag; constant 0 when the timer is compiled out.

Function
REQ-009 The block SHALL decode DataAdr[31:0] as follows:
- 0x000-0x0FF: RAM, 64x32, index DataAdr[7:2].
- 0x100: LED.
- 0x104: CYCLE.
- 0x108: TLOAD.
- 0x10C: TSTAT.
- All other addresses: unmapped.
REQ-010 RAM SHALL read combinationally (zero-wait, same cycle as address) and write on the clk edge when MemWrite=1.
REQ-011 A read of an unmapped address SHALL return 0x00000000; a write to an unmapped address SHALL change no state.
REQ-012 LED register SHALL load WriteData[7:0] on a write; reads return {24'b0, Leds}.
REQ-013 CYCLE SHALL be a 32-bit free-running up-counter, incrementing every clk edge and wrapping 0xFFFFFFFF->0x00000000.
REQ-014 A write to CYCLE SHALL load WriteData; the following edge resumes incrementing from that value.
REQ-015 Timer state machine, when compiled in, SHALL have two states: IDLE (count=0) and RUN (count!=0).
REQ-016 A write to TLOAD with value N SHALL load count<=N at any state. N=0 forces IDLE; N!=0 enters or stays in RUN, which includes reloading mid-run.
REQ-017 In RUN without a TLOAD write, count SHALL decrement by 1 each edge.
REQ-018 The edge where count goes 1->0 SHALL set the expired flag and return to IDLE.
REQ-019 Reads of TLOAD SHALL return the current count.
REQ-020 TSTAT reads SHALL return {31'b0, expired}.
REQ-021 A write to TSTAT with WriteData[0]=1 SHALL clear expired; a write with WriteData[0]=0 SHALL have no effect.
REQ-022 If expiry and a TSTAT clear occur on the same edge, set SHALL win and expired stays 1.
REQ-023 A TLOAD write on the edge where count would reach 0 SHALL take priority: count loads N and expired is not set.
REQ-024 TimerIrq SHALL equal the expired flag, registered, with no combinational path from inputs.

Reset
REQ-025 When reset=0, the block SHALL asynchronously force the following state, independent of clk:
- Leds=0x00.
- CYCLE=0.
- count=0 and timer state IDLE.
- expired=0, so TimerIrq=0.
REQ-026 RAM contents SHALL be unaffected by reset and are undefined after power-up.
REQ-027 Reset asserted mid-count SHALL abort the timer without setting expired.
REQ-028 The first CYCLE increment SHALL occur on the first clk edge after reset deasserts.

Configuration
REQ-029 Macro DATA_BUS_TIMER_EN defined SHALL include the timer: TLOAD, TSTAT, and TimerIrq behave per REQ-015..REQ-024.
REQ-030 Macro DATA_BUS_TIMER_EN undefined SHALL remove the timer logic: 0x108 and 0x10C behave as unmapped (read 0, writes ignored) and TimerIrq is tied to 0.

Verification
REQ-031 The bench SHALL cover RAM access: write 0xDEADBEEF @0x04, then 0x12345678 @0xFC; read 0x04 -> 0xDEADBEEF, read 0xFC -> 0x12345678, read 0x07 -> 0xDEADBEEF.
REQ-032 The bench SHALL cover unmapped access: write 0xFFFFFFFF @0x200, then read 0x200 -> 0x00000000; all RAM, LED, and timer state unchanged.
REQ-033 The bench SHALL cover LED and reset: write 0x1A5 @0x100 -> Leds=0xA5 and read 0x100 -> 0x000000A5; pulse reset low mid-cycle -> Leds=0x00 immediately, before the next edge.
REQ-034 The bench SHALL cover CYCLE wrap: write 0xFFFFFFFE @0x104 -> reads 0xFFFFFFFF, then 0x00000000, on the next two edges.
REQ-035 The bench SHALL cover timer expiry (TIMER_EN): write 3 @0x108 -> TimerIrq rises exactly 3 edges later; then write 1 @0x10C -> TimerIrq=0 on the next edge.
REQ-036 The bench SHALL cover the timer race (TIMER_EN):
- Clear TSTAT on the expiry edge -> TimerIrq stays 1.
- Write 5 @0x108 on the edge where count would reach 0 -> count=5 and TimerIrq unchanged.
